// File: rtl/zbritesi_pkg.sv
// Shared constants and state type for the zbritesi bit-serial subtractor.
// The optional result flags are enabled with the ZBRITESI_FLAGS_EN macro.
package zbritesi_pkg;

  localparam int ZB_WIDTH = 16;
  localparam int ZB_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } zb_state_e;

endpackage

// File: rtl/zbritesi_serial16_if.sv
// Request/result bundle for zbritesi_serial16.
// ZERO/NEG/OVF exist only when ZBRITESI_FLAGS_EN is defined.
interface zbritesi_serial16_if
  import zbritesi_pkg::*;
#(
  parameter int WIDTH = ZB_WIDTH
);

  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] DIFF;
  logic             BOUT;
`ifdef ZBRITESI_FLAGS_EN
  logic             ZERO;
  logic             NEG;
  logic             OVF;
`endif

  modport master (
`ifdef ZBRITESI_FLAGS_EN
    input  ZERO, NEG, OVF,
`endif
    output START, A, B,
    input  BUSY, DONE, DIFF, BOUT
  );

  modport slave (
`ifdef ZBRITESI_FLAGS_EN
    output ZERO, NEG, OVF,
`endif
    input  START, A, B,
    output BUSY, DONE, DIFF, BOUT
  );

endinterface

// File: rtl/zbritesi_serial16_bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module zbritesi_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/zbritesi_serial16.sv
// Bit-serial subtractor: DIFF = A - B, one bit per clock, LSB first.
// Defining ZBRITESI_FLAGS_EN adds the ZERO/NEG/OVF result flags.
module zbritesi_serial16
  import zbritesi_pkg::*;
#(
  parameter int WIDTH = ZB_WIDTH
) (
  input  logic                CLK,
  input  logic                RST,
  zbritesi_serial16_if.slave  bus
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;
  localparam logic [ZB_CNT_W-1:0] CNT_LAST = ZB_CNT_W'(WIDTH - 1);

  logic [1:0]          state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]    work_q, work_d;
  logic [WIDTH-1:0]    diff_q, diff_d;
  logic [ZB_CNT_W-1:0] cnt_q, cnt_d;
  logic                br_q, br_d;
  logic                bout_q, bout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_d, bit_bout;
`ifdef ZBRITESI_FLAGS_EN
  logic                zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
`endif

  zbritesi_bit u_bit (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Next-state, datapath and result-load logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef ZBRITESI_FLAGS_EN
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          state_d = S_RUN;
          a_d     = bus.A;
          b_d     = bus.B;
          br_d    = 1'b0;
          cnt_d   = {ZB_CNT_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        work_d = {bit_d, work_q[WIDTH-1:1]};
        br_d   = bit_bout;
        cnt_d  = cnt_q + {{(ZB_CNT_W-1){1'b0}}, 1'b1};
        // Results load from the freshly shifted word in the same edge as RUN->DONE.
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          diff_d  = work_d;
          bout_d  = bit_bout;
`ifdef ZBRITESI_FLAGS_EN
          zero_d  = (work_d == {WIDTH{1'b0}});
          neg_d   = work_d[WIDTH-1];
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers, cleared asynchronously by RST
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      work_q  <= {WIDTH{1'b0}};
      diff_q  <= {WIDTH{1'b0}};
      cnt_q   <= {ZB_CNT_W{1'b0}};
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ZBRITESI_FLAGS_EN
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ZBRITESI_FLAGS_EN
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.DIFF = diff_q;
  assign bus.BOUT = bout_q;
`ifdef ZBRITESI_FLAGS_EN
  assign bus.ZERO = zero_q;
  assign bus.NEG  = neg_q;
  assign bus.OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_zbritesi_serial16.sv
// Self-checking bench for zbritesi_serial16 against an arithmetic reference model.
// Flag checks are active when ZBRITESI_FLAGS_EN is defined.
module tb_zbritesi_serial16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] held_diff = 16'h0000;
  logic        held_bout = 1'b0;
  logic        held_zero = 1'b0;
  logic        held_neg  = 1'b0;
  logic        held_ovf  = 1'b0;

  zbritesi_serial16_if #(.WIDTH(16)) bus ();

  zbritesi_serial16 #(.WIDTH(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic busy, input logic done);
    check({tag, ".busy"}, {31'd0, bus.BUSY}, {31'd0, busy});
    check({tag, ".done"}, {31'd0, bus.DONE}, {31'd0, done});
    check({tag, ".diff"}, {16'd0, bus.DIFF}, {16'd0, held_diff});
    check({tag, ".bout"}, {31'd0, bus.BOUT}, {31'd0, held_bout});
`ifdef ZBRITESI_FLAGS_EN
    check({tag, ".zero"}, {31'd0, bus.ZERO}, {31'd0, held_zero});
    check({tag, ".neg"},  {31'd0, bus.NEG},  {31'd0, held_neg});
    check({tag, ".ovf"},  {31'd0, bus.OVF},  {31'd0, held_ovf});
`endif
  endtask

  // One operation; glitch>0 pulses START with A=B=1 before edge N+glitch,
  // hold keeps START high so the next call starts at N+18.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input int glitch, input bit hold);
    int sa, sb, sr;
    logic [15:0] exp_diff;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = sa - sb;
    exp_diff = a - b;
    @(negedge CLK);
    bus.START = 1'b1; bus.A = a; bus.B = b;
    @(posedge CLK); #1;
    check("op.edgeN", {30'd0, bus.BUSY, bus.DONE}, {30'd0, 1'b1, 1'b0});
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      bus.START = hold || (k == glitch);
      bus.A = (k == glitch) ? 16'h0001 : 16'($urandom);
      bus.B = (k == glitch) ? 16'h0001 : 16'($urandom);
      @(posedge CLK); #1;
      if (k == 16) begin
        held_diff = exp_diff;
        held_bout = (a < b);
        held_zero = (exp_diff == 16'h0000);
        held_neg  = (sr < 0 && sr >= -32768) || (sr > 32767);
        held_ovf  = (sr > 32767) || (sr < -32768);
        check_outputs($sformatf("op[%h-%h].done", a, b), 1'b0, 1'b1);
      end else if (k == 8 || k == 15 || k == glitch + 1) begin
        check_outputs($sformatf("op[%h-%h].run%0d", a, b, k), 1'b1, 1'b0);
      end else begin
        check("op.run.busy", {30'd0, bus.BUSY, bus.DONE}, {30'd0, 1'b1, 1'b0});
      end
    end
    @(negedge CLK);
    bus.START = hold;
    bus.A = 16'($urandom); bus.B = 16'($urandom);
    @(posedge CLK); #1;
    check_outputs($sformatf("op[%h-%h].after", a, b), 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    bus.START = 1'b0; bus.A = 16'h0000; bus.B = 16'h0000;
    repeat (3) @(posedge CLK);
    #1;
    check_outputs("reset", 1'b0, 1'b0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    check_outputs("idle", 1'b0, 1'b0);

    run_op(16'd10, 16'd9, 0, 1'b0);
    run_op(16'd9, 16'd10, 0, 1'b0);
    check("vec.9m10.diff", {16'd0, held_diff}, 32'h0000FFFF);
    run_op(16'h8000, 16'h0001, 0, 1'b0);
    check("vec.ovf.model", {31'd0, held_ovf}, 32'd1);
    run_op(16'd15, 16'd15, 0, 1'b0);
    check("vec.zero.model", {31'd0, held_zero}, 32'd1);

    // START re-pulsed mid-RUN must be ignored, and nothing queued afterwards
    run_op(16'd10, 16'd9, 5, 1'b0);
    @(posedge CLK); #1;
    check_outputs("noqueue", 1'b0, 1'b0);

    // Back-to-back: START held high chains operations at N+18
    run_op(16'h1234, 16'h0FFF, 0, 1'b1);
    run_op(16'h0001, 16'hFFFF, 0, 1'b1);
    run_op(16'h7FFF, 16'h8000, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = (i % 5 == 0) ? ra : 16'($urandom);
      run_op(ra, rb, 0, (i % 3 == 0));
    end

    // Reset between N+8 and N+9 aborts with no DONE
    @(negedge CLK);
    bus.START = 1'b1; bus.A = 16'd100; bus.B = 16'd3;
    @(posedge CLK);
    @(negedge CLK); bus.START = 1'b0;
    repeat (8) @(posedge CLK);
    #2;
    check("abort.prebusy", {31'd0, bus.BUSY}, 32'd1);
    RST = 1'b1;
    #1;
    held_diff = 16'h0000; held_bout = 1'b0;
    held_zero = 1'b0; held_neg = 1'b0; held_ovf = 1'b0;
    check_outputs("abort.async", 1'b0, 1'b0);
    repeat (10) @(posedge CLK);
    #1;
    check_outputs("abort.nodone", 1'b0, 1'b0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    check_outputs("abort.idle", 1'b0, 1'b0);
    run_op(16'd20, 16'd9, 0, 1'b0);
    check("abort.20m9.diff", {16'd0, bus.DIFF}, 32'h0000000B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
